// File: rtl/sipo_deserializer.sv
// sipo_deserializer
//   Serial-in, parallel-out receiver. Collects WIDTH framed bits from a
//   bit-serial stream (the serial output of the 4-bit parallel-load shift
//   register) and presents the assembled word in a one-entry output register
//   with a valid/ready handshake. Overrun caused by a stalled consumer is
//   flagged in a sticky overflow bit.
//
//   Optional feature macro: SIPO_PARITY_CHECK_EN
//     When defined, every frame carries one trailing even-parity bit and
//     parity_err reports the parity check for the word in out_data. When
//     undefined, frames are exactly WIDTH bits and parity_err is tied to 0.
//
// Parameters
//   WIDTH      data bits per frame (2..32)
//   LSB_FIRST  1: first received bit -> out_data[0]
//              0: first received bit -> out_data[WIDTH-1]
//
// Ports
//   clock      rising-edge clock
//   clear      asynchronous active-low reset of all state
//   sin        serial data bit
//   sin_valid  qualifies sin and start
//   start      marks the current bit as bit 0 of a new frame
//   out_data   assembled word (output register)
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts the word when out_valid && out_ready
//   busy       a frame is partially received
//   overflow   sticky: a completed word was dropped
//   ovf_clr    synchronous clear of overflow (a same-edge set wins)
//   parity_err parity check result registered with out_data
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef SIPO_PARITY_CHECK_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1
  } state_t;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_p0, cnt_nxt;
  logic [CNT_W-1:0] pos;
  logic [CNT_W-1:0] slot;
  logic [WIDTH-1:0] word_p0, word_cap;
  logic             cap;
  logic             commit;
  logic             accept;
  logic             drop;

  // Map a frame bit position to its slot in the assembled word.
  function automatic logic [CNT_W-1:0] slot_of(input logic [CNT_W-1:0] p);
    if (LSB_FIRST) slot_of = p;
    else           slot_of = LAST - p;
  endfunction

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. A start-qualified bit always restarts the frame at
  // position 0, whatever state the receiver is in.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_p0;
    cap       = 1'b0;
    commit    = 1'b0;
    pos       = '0;
    case (state)
      IDLE: begin
        if (sin_valid && start) begin
          cap       = 1'b1;
          cnt_nxt   = CNT_W'(1);
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (sin_valid) begin
          cap = 1'b1;
          if (start) begin
            cnt_nxt = CNT_W'(1);
          end else begin
            pos = cnt_p0;
            if (cnt_p0 == LAST) begin
              cnt_nxt   = '0;
`ifdef SIPO_PARITY_CHECK_EN
              state_nxt = PAR;
`else
              commit    = 1'b1;
              state_nxt = IDLE;
`endif
            end else begin
              cnt_nxt = cnt_p0 + CNT_W'(1);
            end
          end
        end
      end
`ifdef SIPO_PARITY_CHECK_EN
      PAR: begin
        if (sin_valid) begin
          if (start) begin
            cap       = 1'b1;
            cnt_nxt   = CNT_W'(1);
            state_nxt = RECV;
          end else begin
            // sin is the parity bit here; it is not stored in the word
            commit    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Word including the bit captured this cycle, so that the final data bit
  // can be committed on the same edge that samples it.
  always_comb begin
    slot     = slot_of(pos);
    word_cap = word_p0;
    for (int k = 0; k < WIDTH; k++) begin
      if (cap && (slot == CNT_W'(k))) word_cap[k] = sin;
    end
  end

  assign accept = commit && (!out_valid || out_ready);
  assign drop   = commit && out_valid && !out_ready;
  assign busy   = (state != IDLE);

  // ---- stage p0: frame assembly ----
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_p0  <= '0;
      word_p0 <= '0;
    end else begin
      cnt_p0  <= cnt_nxt;
      word_p0 <= word_cap;
    end
  end

  // ---- output register: one-entry handshake buffer ----
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        out_data  <= word_cap;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_CHECK_EN
  // Even parity: XOR over data and parity bit is 0 for a clean frame.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)      parity_err <= 1'b0;
    else if (accept) parity_err <= (^word_p0) ^ sin;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       sin = 1'b0, sin_valid = 1'b0, start = 1'b0;
  logic       out_ready = 1'b0, ovf_clr = 1'b0;
  logic [3:0] od, om;
  logic       ov, ov_m, busy, busy_m, ovf, ovf_m, perr, perr_m;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut (
    .clock(clock), .clear(clear), .sin(sin), .sin_valid(sin_valid),
    .start(start), .out_data(od), .out_valid(ov), .out_ready(out_ready),
    .busy(busy), .overflow(ovf), .ovf_clr(ovf_clr), .parity_err(perr)
  );

  sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_msb (
    .clock(clock), .clear(clear), .sin(sin), .sin_valid(sin_valid),
    .start(start), .out_data(om), .out_valid(ov_m), .out_ready(out_ready),
    .busy(busy_m), .overflow(ovf_m), .ovf_clr(ovf_clr), .parity_err(perr_m)
  );

  typedef struct {
    logic       v, st, s, rdy, clr;
    logic       ov;
    logic [3:0] od, om;
    logic       busy, ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, st, s, rdy, clr,
                     input logic e_ov, input logic [3:0] e_od, e_om,
                     input logic e_busy, e_ovf);
    vec_t r;
    r.v = v; r.st = st; r.s = s; r.rdy = rdy; r.clr = clr;
    r.ov = e_ov; r.od = e_od; r.om = e_om; r.busy = e_busy; r.ovf = e_ovf;
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input logic v, st, s, rdy, clr);
    sin_valid = v; start = st; sin = s; out_ready = rdy; ovf_clr = clr;
    @(posedge clock);
    #1;
  endtask

  // Full frame with out_ready=1; checks the committed word.
  task automatic send_frame(input string name, input logic [3:0] bits,
                            input logic [3:0] exp_msb, input logic par,
                            input logic exp_perr);
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, bits[i], 1'b1, 1'b0);
`ifdef SIPO_PARITY_CHECK_EN
    check({name, " busy_par"}, 32'(busy), 32'(1));
    check({name, " ov_pre"}, 32'(ov), 32'(0));
    step(1'b1, 1'b0, par, 1'b1, 1'b0);
`endif
    check({name, " ov"}, 32'(ov), 32'(1));
    check({name, " data"}, 32'(od), 32'(bits));
    check({name, " data_msb"}, 32'(om), 32'(exp_msb));
    check({name, " perr"}, 32'(perr), 32'(exp_perr));
    check({name, " busy"}, 32'(busy), 32'(0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check({name, " popped"}, 32'(ov), 32'(0));
  endtask

  initial begin
    // ---------------- reset ----------------
    for (int i = 0; i < 2; i++) begin
      step(i == 0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("rst data", 32'(od), 32'(0));
      check("rst ov", 32'(ov), 32'(0));
      check("rst busy", 32'(busy), 32'(0));
      check("rst ovf", 32'(ovf), 32'(0));
    end
    clear = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post-rst data", 32'(od), 32'(0));
    check("post-rst ov", 32'(ov), 32'(0));
    check("post-rst busy", 32'(busy), 32'(0));
    check("post-rst ovf", 32'(ovf), 32'(0));
    check("post-rst perr", 32'(perr), 32'(0));

`ifndef SIPO_PARITY_CHECK_EN
    //  v  st s  rdy clr | ov od    om    busy ovf
    add(1, 0, 1, 1, 0,   0, 4'h0, 4'h0, 0, 0);   // bit without start ignored
    // back-to-back 1,0,1,1
    add(1, 1, 1, 1, 0,   0, 4'h0, 4'h0, 1, 0);
    add(1, 0, 0, 1, 0,   0, 4'h0, 4'h0, 1, 0);
    add(1, 0, 1, 1, 0,   0, 4'h0, 4'h0, 1, 0);
    add(1, 0, 1, 1, 0,   1, 4'hD, 4'hB, 0, 0);
    add(0, 0, 1, 1, 0,   0, 4'hD, 4'hB, 0, 0);
    // all-zero frame
    add(1, 1, 0, 1, 0,   0, 4'hD, 4'hB, 1, 0);
    add(1, 0, 0, 1, 0,   0, 4'hD, 4'hB, 1, 0);
    add(1, 0, 0, 1, 0,   0, 4'hD, 4'hB, 1, 0);
    add(1, 0, 0, 1, 0,   1, 4'h0, 4'h0, 0, 0);
    // gapped 1,0,1,1; junk sin/start while sin_valid=0
    add(1, 1, 1, 1, 0,   0, 4'h0, 4'h0, 1, 0);
    add(0, 0, 0, 1, 0,   0, 4'h0, 4'h0, 1, 0);
    add(0, 1, 1, 1, 0,   0, 4'h0, 4'h0, 1, 0);
    add(1, 0, 0, 1, 0,   0, 4'h0, 4'h0, 1, 0);
    add(0, 0, 1, 1, 0,   0, 4'h0, 4'h0, 1, 0);
    add(0, 1, 1, 1, 0,   0, 4'h0, 4'h0, 1, 0);
    add(1, 0, 1, 1, 0,   0, 4'h0, 4'h0, 1, 0);
    add(0, 0, 0, 1, 0,   0, 4'h0, 4'h0, 1, 0);
    add(0, 1, 0, 1, 0,   0, 4'h0, 4'h0, 1, 0);
    add(1, 0, 1, 1, 0,   1, 4'hD, 4'hB, 0, 0);
    add(0, 0, 0, 1, 0,   0, 4'hD, 4'hB, 0, 0);
    // backpressure: 0xD held, then 0,1,1,0 dropped
    add(1, 1, 1, 0, 0,   0, 4'hD, 4'hB, 1, 0);
    add(1, 0, 0, 0, 0,   0, 4'hD, 4'hB, 1, 0);
    add(1, 0, 1, 0, 0,   0, 4'hD, 4'hB, 1, 0);
    add(1, 0, 1, 0, 0,   1, 4'hD, 4'hB, 0, 0);
    add(1, 1, 0, 0, 0,   1, 4'hD, 4'hB, 1, 0);
    add(1, 0, 1, 0, 0,   1, 4'hD, 4'hB, 1, 0);
    add(1, 0, 1, 0, 0,   1, 4'hD, 4'hB, 1, 0);
    add(1, 0, 0, 0, 0,   1, 4'hD, 4'hB, 0, 1);
    add(0, 0, 0, 1, 0,   0, 4'hD, 4'hB, 0, 1);   // single pop
    add(0, 0, 0, 0, 0,   0, 4'hD, 4'hB, 0, 1);
    add(0, 0, 0, 0, 1,   0, 4'hD, 4'hB, 0, 0);   // ovf_clr
    // set wins over clear; commit coincident with pop
    add(1, 1, 1, 0, 0,   0, 4'hD, 4'hB, 1, 0);
    add(1, 0, 0, 0, 0,   0, 4'hD, 4'hB, 1, 0);
    add(1, 0, 0, 0, 0,   0, 4'hD, 4'hB, 1, 0);
    add(1, 0, 0, 0, 0,   1, 4'h1, 4'h8, 0, 0);
    add(1, 1, 0, 0, 0,   1, 4'h1, 4'h8, 1, 0);
    add(1, 0, 1, 0, 0,   1, 4'h1, 4'h8, 1, 0);
    add(1, 0, 0, 0, 0,   1, 4'h1, 4'h8, 1, 0);
    add(1, 0, 0, 0, 1,   1, 4'h1, 4'h8, 0, 1);   // drop + ovf_clr -> set
    add(1, 1, 0, 0, 1,   1, 4'h1, 4'h8, 1, 0);
    add(1, 0, 0, 0, 0,   1, 4'h1, 4'h8, 1, 0);
    add(1, 0, 1, 0, 0,   1, 4'h1, 4'h8, 1, 0);
    add(1, 0, 1, 1, 0,   1, 4'hC, 4'h3, 0, 0);   // pop + commit same edge
    add(0, 0, 0, 1, 0,   0, 4'hC, 4'h3, 0, 0);
    // restart: 1,1 then start frame 1,1,0,0
    add(1, 1, 1, 1, 0,   0, 4'hC, 4'h3, 1, 0);
    add(1, 0, 1, 1, 0,   0, 4'hC, 4'h3, 1, 0);
    add(1, 1, 1, 1, 0,   0, 4'hC, 4'h3, 1, 0);
    add(1, 0, 1, 1, 0,   0, 4'hC, 4'h3, 1, 0);
    add(1, 0, 0, 1, 0,   0, 4'hC, 4'h3, 1, 0);
    add(1, 0, 0, 1, 0,   1, 4'h3, 4'hC, 0, 0);
    add(0, 0, 0, 1, 0,   0, 4'h3, 4'hC, 0, 0);
    // restart on the last bit position: 1,1,1 then start frame 0,1,0,1
    add(1, 1, 1, 1, 0,   0, 4'h3, 4'hC, 1, 0);
    add(1, 0, 1, 1, 0,   0, 4'h3, 4'hC, 1, 0);
    add(1, 0, 1, 1, 0,   0, 4'h3, 4'hC, 1, 0);
    add(1, 1, 0, 1, 0,   0, 4'h3, 4'hC, 1, 0);
    add(1, 0, 1, 1, 0,   0, 4'h3, 4'hC, 1, 0);
    add(1, 0, 0, 1, 0,   0, 4'h3, 4'hC, 1, 0);
    add(1, 0, 1, 1, 0,   1, 4'hA, 4'h5, 0, 0);
    add(0, 0, 0, 1, 0,   0, 4'hA, 4'h5, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].st, tbl[i].s, tbl[i].rdy, tbl[i].clr);
      check($sformatf("row%0d ov", i), 32'(ov), 32'(tbl[i].ov));
      check($sformatf("row%0d data", i), 32'(od), 32'(tbl[i].od));
      check($sformatf("row%0d data_msb", i), 32'(om), 32'(tbl[i].om));
      check($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("row%0d ovf", i), 32'(ovf), 32'(tbl[i].ovf));
      check($sformatf("row%0d ov_msb", i), 32'(ov_m), 32'(tbl[i].ov));
      check($sformatf("row%0d busy_msb", i), 32'(busy_m), 32'(tbl[i].busy));
      check($sformatf("row%0d ovf_msb", i), 32'(ovf_m), 32'(tbl[i].ovf));
      check($sformatf("row%0d perr", i), 32'(perr), 32'(0));
      check($sformatf("row%0d perr_msb", i), 32'(perr_m), 32'(0));
    end
`else
    // parity frames: 1,0,1,1 has odd data weight
    send_frame("par_ok", 4'hD, 4'hB, 1'b1, 1'b0);
    send_frame("par_bad", 4'hD, 4'hB, 1'b0, 1'b1);
    send_frame("par_zero", 4'h0, 4'h0, 1'b0, 1'b0);
    // start during PAR restarts the frame: 1,1,1,1 then start frame 0,1,1,0
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("par_restart busy", 32'(busy), 32'(1));
    check("par_restart ov", 32'(ov), 32'(0));
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("par_restart ov_pre", 32'(ov), 32'(0));
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("par_restart ov", 32'(ov), 32'(1));
    check("par_restart data", 32'(od), 32'(4'h6));
    check("par_restart perr", 32'(perr), 32'(0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // ---------------- reset mid-frame ----------------
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("mid busy pre", 32'(busy), 32'(1));
    clear = 1'b0;
    #1;
    check("mid-rst busy", 32'(busy), 32'(0));
    check("mid-rst ov", 32'(ov), 32'(0));
    check("mid-rst data", 32'(od), 32'(0));
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    clear = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);   // no start: ignored after reset
    check("after-rst busy", 32'(busy), 32'(0));
    check("after-rst ov", 32'(ov), 32'(0));
    send_frame("after-rst", 4'hD, 4'hB, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in, parallel-out receiver. It is the far end of the team's 4-bit parallel-load shift register, whose serial output E feeds this block's sin.
- Collects WIDTH framed bits from a bit-serial stream and presents the assembled word on a one-entry output register with a valid/ready handshake.
- Detects and flags overrun when the consumer stalls.

Parameters:
- WIDTH, 4: data bits per frame. Legal range 2..32.
- LSB_FIRST, 1: 1 = first received bit lands in out_data[0]; 0 = first received bit lands in out_data[WIDTH-1].

Ports:
- clock, input, 1: single clock. All state updates on the rising edge.
- clear, input, 1: reset, asynchronous assert, active-low. clear=0 resets all state.
- sin, input, 1: serial data bit.
- sin_valid, input, 1: sin is sampled only on cycles where this is 1.
- start, input, 1: frame marker. Qualified by sin_valid; marks the current bit as bit 0 of a new frame.
- out_data, output, WIDTH: assembled word, held in the output register.
- out_valid, output, 1: out_data holds an unconsumed word.
- out_ready, input, 1: consumer accepts the word when out_valid && out_ready.
- busy, output, 1: a frame is partially received.
- overflow, output, 1: sticky; a completed word was dropped.
- ovf_clr, input, 1: synchronous clear of overflow.
- parity_err, output, 1: parity result for the word in out_data (see Optional Feature).

Behaviour:
- Reset (clear=0, asynchronous):
  - out_data=0, out_valid=0, busy=0, overflow=0, parity_err=0.
  - FSM goes to IDLE; bit counter=0; any partial word is discarded.
- FSM states: IDLE, RECV, and PAR (PAR exists only with the macro).
- IDLE:
  - sin_valid=1 && start=1: capture sin as bit 0, counter=1, go to RECV.
  - sin_valid=1 with start=0: the bit is ignored.
- RECV:
  - On each sin_valid=1 cycle, capture sin at position counter, then increment counter.
  - sin_valid=0: hold all state.
  - Capture of bit WIDTH-1: the word commits to the output register on the same edge, counter=0, next state IDLE (or PAR with the macro).
- Frame restart: start=1 && sin_valid=1 while in RECV (or PAR) aborts the partial frame. The current bit becomes bit 0 of the new frame, counter=1. No flag is raised.
- busy = (state != IDLE).
- Commit latency: out_valid rises in the cycle after the edge that samples the final bit.
- Output register:
  - Pop: out_valid && out_ready at an edge clears out_valid, unless a commit occurs on the same edge.
  - Commit with the register empty, or popped on the same edge: load out_data, out_valid=1.
  - Commit with out_valid=1 && out_ready=0: new word dropped; out_data and parity_err are kept; overflow is set to 1.
- overflow:
  - Cleared by ovf_clr=1 at an edge.
  - Set wins if a set and ovf_clr occur on the same edge.
- Bit ordering:
  - LSB_FIRST=1: bit k goes to out_data[k].
  - LSB_FIRST=0: bit k goes to out_data[WIDTH-1-k].
- Values of sin on cycles with sin_valid=0 have no effect.

Optional Feature:
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - After data bit WIDTH-1 the FSM enters PAR instead of committing.
  - The next sin_valid=1 bit is the even-parity bit. Commit happens on that edge.
  - parity_err = XOR of all data bits and the parity bit, registered together with out_data.
  - start during PAR aborts the frame (restart rule applies).
  - Commit latency grows by one bit.
- Undefined:
  - PAR state and parity logic are not built.
  - parity_err is a constant 0.
  - Frames are exactly WIDTH bits.

Test Plan (WIDTH=4, LSB_FIRST=1 unless noted):
1. Reset: hold clear=0 for 2 cycles while sin_valid toggles -> out_data=0, out_valid=0, busy=0, overflow=0. Release clear -> all stay 0.
2. Back-to-back frame: sin_valid=1 every cycle, start on the first bit, bits 1,0,1,1, out_ready=1 -> out_valid=1 for one cycle, starting the cycle after the 4th bit; out_data=4'hD. busy=1 for 3 cycles.
3. Gapped bits: same frame with 2 idle cycles between bits -> out_data=4'hD, busy held high through the gaps. Repeat with LSB_FIRST=0 -> out_data=4'hB.
4. Backpressure: out_ready=0; send 0xD, then bits 0,1,1,0 -> out_data stays 0xD, overflow=1. Raise out_ready -> one pop of 0xD. Pulse ovf_clr -> overflow=0.
5. Restart and reset mid-frame:
   - Start with bits 1,1, then a start-qualified frame 1,1,0,0 -> single word 0x3.
   - Separately, clear=0 after 2 bits -> no out_valid; the next full frame decodes correctly.
6. Parity (SIPO_PARITY_CHECK_EN defined):
   - 0xD plus parity bit 1 -> out_data=0xD, parity_err=0.
   - 0xD plus parity bit 0 -> parity_err=1.
   - Without the macro, the 4-bit frame 0xD -> parity_err=0.
